// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave front-end for the SoC block RAM.
// Zero-wait-state reads and writes, byte-lane write enables, and forwarding
// of write data into an immediately following read of the same word.
// Optional build macro AHB_BRAM_ERRRESP_EN: misaligned accesses get a
// two-cycle ERROR response instead of being aligned down.
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  trans_en;
  logic                  xfer_ok;
  logic                  wr_accept;
  logic                  hazard;
  logic [3:0]            lanes;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_lanes;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;

  // Address bits above the RAM size alias; protection and the SEQ/NONSEQ
  // distinction do not affect this slave.
  logic unused_bits;
  assign unused_bits = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  assign trans_en  = HSEL & HREADY & HTRANS[1];
  assign word_addr = HADDR[ADDR_WIDTH+1:2];

  assign BRAM_RDADDR = word_addr;
  assign BRAM_WRADDR = wr_addr;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRITE  = wr_pend ? wr_lanes : 4'b0000;

  // Byte lanes of the transfer in its address phase.
  always_comb begin
    lanes = 4'b1111;
    case (HSIZE)
      3'd0:    lanes = 4'b0001 << HADDR[1:0];
      3'd1:    lanes = 4'b0011 << {HADDR[1], 1'b0};
      default: lanes = 4'b1111;
    endcase
  end

`ifdef AHB_BRAM_ERRRESP_EN
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

  err_state_t state, state_nxt;
  logic       misaligned;

  assign misaligned = ((HSIZE == 3'd1) & HADDR[0]) |
                      ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00)) |
                      (HSIZE > 3'd2);
  assign xfer_ok    = ~misaligned;

  // Error-response state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_OKAY;
    else          state <= state_nxt;
  end

  // Two-cycle ERROR sequence; a new transfer may start in ERR2.
  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_OKAY: begin
        if (trans_en && misaligned) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = (trans_en && misaligned) ? ST_ERR1 : ST_OKAY;
      end
      default: state_nxt = ST_OKAY;
    endcase
  end
`else
  assign xfer_ok   = 1'b1;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  assign wr_accept = trans_en & HWRITE & xfer_ok;
  // The RAM returns the old word when reading a word whose write commits in
  // this same cycle, so that read must take the data from HWDATA instead.
  assign hazard    = trans_en & ~HWRITE & xfer_ok & wr_pend & (word_addr == wr_addr);

  // Capture accepted writes for their data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_lanes <= 4'b0000;
    end else if (HREADY) begin
      wr_pend <= wr_accept;
      if (wr_accept) begin
        wr_addr  <= word_addr;
        wr_lanes <= lanes;
      end
    end
  end

  // Remember the bytes to forward into the read data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_mask <= 4'b0000;
      fwd_data <= 32'h0;
    end else begin
      fwd_mask <= hazard ? wr_lanes : 4'b0000;
      if (hazard) fwd_data <= HWDATA;
    end
  end

  // Per-byte merge of forwarded write data over RAM read data.
  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (fwd_mask[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Directed bench for ahb_bram_bridge with a behavioural one-cycle-latency RAM.
module tb_ahb_bram_bridge;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [3:0]    hprot;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic [AW-1:0] bram_rdaddr;
  logic [AW-1:0] bram_wraddr;
  logic [31:0]   bram_wdata;
  logic [3:0]    bram_write;
  logic [31:0]   bram_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .BRAM_RDADDR(bram_rdaddr), .BRAM_WRADDR(bram_wraddr), .BRAM_WDATA(bram_wdata),
    .BRAM_WRITE(bram_write), .BRAM_RDATA(bram_rdata)
  );

  // RAM model: registered read (old data on same-cycle write), byte writes.
  always @(posedge clk) begin
    bram_rdata <= mem[bram_rdaddr];
    for (int b = 0; b < 4; b++)
      if (bram_write[b]) mem[bram_wraddr][8*b +: 8] <= bram_wdata[8*b +: 8];
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [AW-1:0] exp_wa;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic [2:0] size, input logic write, input logic [31:0] wdata);
    hsel = sel; htrans = trans; haddr = addr; hsize = size; hwrite = write; hwdata = wdata;
  endtask

  task automatic add(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic [2:0] size, input logic write, input logic [31:0] wdata,
                     input logic [3:0] exp_we, input logic [AW-1:0] exp_wa,
                     input logic chk_rd, input logic [31:0] exp_rd);
    vec_t v;
    v.sel = sel; v.trans = trans; v.addr = addr; v.size = size; v.write = write;
    v.wdata = wdata; v.exp_we = exp_we; v.exp_wa = exp_wa; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    hprot = 4'h0;
    drive(0, 2'd0, 32'h0, 3'd0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while a write to 0x10 is in its data phase.
    @(posedge clk); #1 drive(1, 2'd2, 32'h10, 3'd2, 1, 32'h0);
    @(posedge clk); #1 drive(0, 2'd0, 32'h0, 3'd0, 0, 32'hDEADBEEF);
    #1 chk("rst_pre_we", {28'h0, bram_write}, 32'hF);
    rst_n = 1'b0;
    #1 chk("rst_we", {28'h0, bram_write}, 32'h0);
    chk("rst_ready", {31'h0, hreadyout}, 32'h1);
    chk("rst_resp", {31'h0, hresp}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 2'd2, 32'h10, 3'd2, 0, 32'h0);
    @(posedge clk); #1 drive(0, 2'd0, 32'h0, 3'd0, 0, 32'h0);
    @(negedge clk) chk("rst_word10", hrdata, 32'h0);
    @(posedge clk); #1;

    // sel trans addr size write wdata | exp_we exp_wa chk_rd exp_rd
    add(1, 2, 32'h20, 2, 1, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h11223344, 4'hF, 8,     0, 0);
    add(1, 2, 32'h20, 2, 0, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'h11223344);
    add(1, 2, 32'h23, 0, 1, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'hAA000000, 4'h8, 8,     0, 0);
    add(1, 2, 32'h20, 2, 0, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'hAA223344);
    add(1, 2, 32'h42, 1, 1, 32'h0,        4'h0, 0,     0, 0);
    add(1, 2, 32'h40, 2, 0, 32'hBEEF0000, 4'hC, 'h10,  0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'hBEEF0000);
    add(1, 2, 32'h40, 2, 0, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'hBEEF0000);
    add(1, 1, 32'h40, 2, 1, 32'h0,        4'h0, 0,     0, 0);
    add(0, 2, 32'h40, 2, 1, 32'hFFFFFFFF, 4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'hFFFFFFFF, 4'h0, 0,     0, 0);
    add(1, 2, 32'h40, 2, 0, 32'h0,        4'h0, 0,     0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'hBEEF0000);
    add(1, 2, 32'h80, 2, 1, 32'h0,        4'h0, 0,     0, 0);
    add(1, 3, 32'h81, 0, 1, 32'h01020304, 4'hF, 'h20,  0, 0);
    add(1, 3, 32'h84, 2, 1, 32'h0000AB00, 4'h2, 'h20,  0, 0);
    add(1, 2, 32'h80, 2, 0, 32'h55667788, 4'hF, 'h21,  0, 0);
    add(1, 3, 32'h84, 2, 0, 32'h0,        4'h0, 0,     1, 32'h0102AB04);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'h55667788);
    add(1, 2, 32'h00010030, 2, 1, 32'h0,  4'h0, 0,     0, 0);
    add(1, 2, 32'h30, 2, 0, 32'hCAFEF00D, 4'hF, 'hC,   0, 0);
    add(1, 2, 32'h30, 2, 0, 32'h0,        4'h0, 0,     1, 32'hCAFEF00D);
    add(0, 0, 32'h0,  0, 0, 32'h0,        4'h0, 0,     1, 32'hCAFEF00D);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].trans, vecs[i].addr, vecs[i].size, vecs[i].write, vecs[i].wdata);
      hprot = 4'(i);
      @(negedge clk);
      chk($sformatf("v%0d_we", i), {28'h0, bram_write}, {28'h0, vecs[i].exp_we});
      chk($sformatf("v%0d_rdaddr", i), {{(32-AW){1'b0}}, bram_rdaddr},
          {{(32-AW){1'b0}}, vecs[i].addr[AW+1:2]});
      chk($sformatf("v%0d_ready", i), {31'h0, hreadyout}, 32'h1);
      chk($sformatf("v%0d_resp", i), {31'h0, hresp}, 32'h0);
      if (vecs[i].exp_we != 4'h0) begin
        chk($sformatf("v%0d_wraddr", i), {{(32-AW){1'b0}}, bram_wraddr},
            {{(32-AW){1'b0}}, vecs[i].exp_wa});
        chk($sformatf("v%0d_wdata", i), bram_wdata, vecs[i].wdata);
      end
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), hrdata, vecs[i].exp_rd);
      @(posedge clk); #1;
    end

    // Misaligned word write to 0x02, read of 0x00 presented right after.
    drive(1, 2'd2, 32'h02, 3'd2, 1, 32'h0);
    @(negedge clk) chk("mis_a_ready", {31'h0, hreadyout}, 32'h1);
    @(posedge clk); #1 drive(0, 2'd0, 32'h0, 3'd0, 0, 32'h12345678);
    @(negedge clk);
`ifdef AHB_BRAM_ERRRESP_EN
    chk("mis_b_ready", {31'h0, hreadyout}, 32'h0);
    chk("mis_b_resp", {31'h0, hresp}, 32'h1);
    chk("mis_b_we", {28'h0, bram_write}, 32'h0);
`else
    chk("mis_b_ready", {31'h0, hreadyout}, 32'h1);
    chk("mis_b_resp", {31'h0, hresp}, 32'h0);
    chk("mis_b_we", {28'h0, bram_write}, 32'hF);
    chk("mis_b_wraddr", {{(32-AW){1'b0}}, bram_wraddr}, 32'h0);
`endif
    @(posedge clk); #1 drive(1, 2'd2, 32'h0, 3'd2, 0, 32'h0);
    @(negedge clk);
    chk("mis_c_ready", {31'h0, hreadyout}, 32'h1);
    chk("mis_c_we", {28'h0, bram_write}, 32'h0);
`ifdef AHB_BRAM_ERRRESP_EN
    chk("mis_c_resp", {31'h0, hresp}, 32'h1);
`else
    chk("mis_c_resp", {31'h0, hresp}, 32'h0);
`endif
    @(posedge clk); #1 drive(0, 2'd0, 32'h0, 3'd0, 0, 32'h0);
    @(negedge clk);
    chk("mis_d_resp", {31'h0, hresp}, 32'h0);
`ifdef AHB_BRAM_ERRRESP_EN
    chk("mis_d_rdata", hrdata, 32'h0);
`else
    chk("mis_d_rdata", hrdata, 32'h12345678);
`endif
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
